fp32_normalize_pack: RTL and testbench

Pipelined FP32 post-normalizer and packer for the systolic-array PE datapath. It accepts an unnormalized 48-bit magnitude with sign and biased exponent, counts leading zeros, shifts, rounds to nearest-even, handles overflow and flush-to-zero, and emits a packed IEEE-754 single-precision word. It is the output-side counterpart of the mantissa leading-zero detection logic and sits between the PE multiply/accumulate core and the result drain path. Flow control is valid/ready throughout, with a fixed 3-stage pipeline.

---
 rtl/fp32_normalize_pack_pkg.sv | 24 ++
 rtl/fp32_normalize_pack_if.sv | 26 ++
 rtl/fp32_normalize_pack_round.sv | 54 +++++
 rtl/fp32_normalize_pack.sv | 99 +++++++++
 tb/tb_fp32_normalize_pack.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/fp32_normalize_pack_pkg.sv
// Shared FP32 constants, flag bit positions and the 48-bit leading-zero counter
// used by the normalize/pack pipeline and the adder path.
package fp32_pkg;

   localparam int          EXP_BIAS = 127;
   localparam int          EXP_MAX  = 255;
   localparam logic [31:0] QNAN     = 32'h7FC00000;
   localparam logic [30:0] INF_MAG  = 31'h7F800000;

   localparam int FLG_OVF = 2;
   localparam int FLG_UNF = 1;
   localparam int FLG_INX = 0;

   // Highest set bit wins because the scan runs upward; 48 means no bit set.
   function automatic logic [5:0] lzc48(input logic [47:0] m);
      logic [5:0] cnt;
      cnt = 6'd48;
      for (int i = 0; i < 48; i++) begin
         if (m[i]) cnt = 6'(47 - i);
      end
      return cnt;
   endfunction

endpackage

// File: rtl/fp32_normalize_pack_if.sv
// Valid/ready bundle between the PE core, the normalizer and the drain path.
interface fp32_normalize_pack_if;

   logic        in_valid;
   logic        in_ready;
   logic        in_sign;
   logic [9:0]  in_exp;
   logic [47:0] in_mant;
   logic        in_nan;
   logic        in_inf;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [2:0]  out_flags;

   modport master (
      output in_valid, in_sign, in_exp, in_mant, in_nan, in_inf, out_ready,
      input  in_ready, out_valid, out_data, out_flags
   );

   modport slave (
      input  in_valid, in_sign, in_exp, in_mant, in_nan, in_inf, out_ready,
      output in_ready, out_valid, out_data, out_flags
   );

endinterface

// File: rtl/fp32_normalize_pack_round.sv
// Combinational round-to-nearest-even and special-case mux for a normalized
// mantissa (leading one already at the implicit position, dropped here).
module fp32_round_pack
   import fp32_pkg::*;
(
   input  logic        i_sign,
   input  logic [10:0] i_exp,
   input  logic [46:0] i_mant,
   input  logic        i_nan,
   input  logic        i_inf,
   input  logic        i_zero,
   output logic [31:0] o_data,
   output logic [2:0]  o_flags
);

   logic [22:0]        w_frac;
   logic               w_guard;
   logic               w_sticky;
   logic               w_roundUp;
   logic [23:0]        w_sum;
   logic signed [10:0] w_exp;

   assign w_frac    = i_mant[46:24];
   assign w_guard   = i_mant[23];
   assign w_sticky  = |i_mant[22:0];
   assign w_roundUp = w_guard & (w_sticky | w_frac[0]);
   assign w_sum     = {1'b0, w_frac} + {23'd0, w_roundUp};
   // A fraction carry leaves w_sum[22:0] at zero, so only the exponent moves.
   assign w_exp     = $signed(i_exp + {10'd0, w_sum[23]});

   always_comb begin
      o_data  = '0;
      o_flags = '0;
      if (i_nan) begin
         o_data = QNAN;
      end else if (i_inf) begin
         o_data = {i_sign, INF_MAG};
      end else if (i_zero) begin
         o_data = {i_sign, 31'd0};
      end else if (w_exp >= $signed(11'(EXP_MAX))) begin
         o_data           = {i_sign, INF_MAG};
         o_flags[FLG_OVF] = 1'b1;
         o_flags[FLG_INX] = 1'b1;
      end else if (w_exp <= 11'sd0) begin
         o_data           = {i_sign, 31'd0};
         o_flags[FLG_UNF] = 1'b1;
         o_flags[FLG_INX] = 1'b1;
      end else begin
         o_data           = {i_sign, w_exp[7:0], w_sum[22:0]};
         o_flags[FLG_INX] = w_guard | w_sticky;
      end
   end

endmodule

// File: rtl/fp32_normalize_pack.sv
// Three-stage FP32 post-normalizer: detect leading zeros, shift, round/pack.
// Each stage carries a valid bit and loads when empty or draining.
module fp32_normalize_pack
   import fp32_pkg::*;
(
   input  logic                        clk,
   input  logic                        rst_n,
   fp32_normalize_pack_if.slave        i_bus
);

   logic        r_v1, r_v2, r_v3;
   logic        w_adv1, w_adv2, w_adv3;
   logic        w_inReady, w_accept;

   logic        r_sign1, r_nan1, r_inf1;
   logic [9:0]  r_exp1;
   logic [47:0] r_mant1;
   logic [5:0]  w_lz;

   logic        r_sign2, r_nan2, r_inf2, r_zero2;
   logic [10:0] r_exp2;
   logic [46:0] r_mant2;
   logic [47:0] w_shift;
   logic [10:0] w_exp2;

   logic [31:0] r_data, w_data;
   logic [2:0]  r_flags, w_flags;

   assign w_adv3    = r_v3 & i_bus.out_ready;
   assign w_adv2    = r_v2 & (~r_v3 | w_adv3);
   assign w_adv1    = r_v1 & (~r_v2 | w_adv2);
   assign w_inReady = ~r_v1 | w_adv1;
   assign w_accept  = i_bus.in_valid & w_inReady;

   assign i_bus.in_ready  = w_inReady;
   assign i_bus.out_valid = r_v3;
   assign i_bus.out_data  = r_data;
   assign i_bus.out_flags = r_flags;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v1 <= 1'b0;
         r_v2 <= 1'b0;
         r_v3 <= 1'b0;
      end else begin
         r_v1 <= w_accept | (r_v1 & ~w_adv1);
         r_v2 <= w_adv1   | (r_v2 & ~w_adv2);
         r_v3 <= w_adv2   | (r_v3 & ~w_adv3);
      end
   end

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_sign1 <= i_bus.in_sign;
         r_exp1  <= i_bus.in_exp;
         r_mant1 <= i_bus.in_mant;
         r_nan1  <= i_bus.in_nan;
         r_inf1  <= i_bus.in_inf;
      end
   end

   assign w_lz    = lzc48(r_mant1);
   assign w_shift = r_mant1 << w_lz;
   assign w_exp2  = {r_exp1[9], r_exp1} + 11'd1 - {5'd0, w_lz};

   // A zero magnitude is the only case where no one reaches bit 47.
   always_ff @(posedge clk) begin
      if (w_adv1) begin
         r_sign2 <= r_sign1;
         r_nan2  <= r_nan1;
         r_inf2  <= r_inf1;
         r_zero2 <= ~w_shift[47];
         r_exp2  <= w_exp2;
         r_mant2 <= w_shift[46:0];
      end
   end

   fp32_round_pack u_roundPack (
      .i_sign  (r_sign2),
      .i_exp   (r_exp2),
      .i_mant  (r_mant2),
      .i_nan   (r_nan2),
      .i_inf   (r_inf2),
      .i_zero  (r_zero2),
      .o_data  (w_data),
      .o_flags (w_flags)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data  <= '0;
         r_flags <= '0;
      end else if (w_adv2) begin
         r_data  <= w_data;
         r_flags <= w_flags;
      end
   end

endmodule

// File: tb/tb_fp32_normalize_pack.sv
// Scoreboard bench for fp32_normalize_pack: directed vectors, backpressure,
// latency and mid-flight reset.
module tb_fp32_normalize_pack;
   import fp32_pkg::*;

   typedef struct {
      logic        sign;
      logic [9:0]  exp;
      logic [47:0] mant;
      logic        nan;
      logic        inf;
      logic [31:0] data;
      logic [2:0]  flags;
   } vec_t;

   typedef struct {
      logic [31:0] data;
      logic [2:0]  flags;
      int          id;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fp32_normalize_pack_if bus();

   fp32_normalize_pack dut (
      .clk   (clk),
      .rst_n (rst_n),
      .i_bus (bus.slave)
   );

   vec_t vecs[$];
   exp_t sbQ[$];
   int   checks = 0;
   int   passes = 0;
   int   expectedOut = 0;
   int   received = 0;

   logic [31:0] holdData;
   logic [2:0]  holdFlags;
   bit          holding = 0;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act === req) passes++;
      else $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h", name, act, req);
   endtask

   function automatic void addVec(input logic s, input logic [9:0] e, input logic [47:0] m,
                                  input logic n, input logic i, input logic [31:0] d,
                                  input logic [2:0] f);
      vec_t v;
      v.sign = s; v.exp = e; v.mant = m; v.nan = n; v.inf = i; v.data = d; v.flags = f;
      vecs.push_back(v);
   endfunction

   task automatic applyStimulus(input vec_t v, input int id);
      bit   acc;
      exp_t e;
      acc = 0;
      bus.in_sign  = v.sign;
      bus.in_exp   = v.exp;
      bus.in_mant  = v.mant;
      bus.in_nan   = v.nan;
      bus.in_inf   = v.inf;
      bus.in_valid = 1'b1;
      for (int k = 0; k < 100 && !acc; k++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            acc = 1;
            e.data = v.data; e.flags = v.flags; e.id = id;
            sbQ.push_back(e);
            expectedOut++;
         end
         @(posedge clk);
         #1;
      end
      checkOutput($sformatf("accept%0d", id), 64'(acc), 64'(1));
      bus.in_valid = 1'b0;
   endtask

   task automatic measureLatency(input string name);
      int n;
      n = 1;
      while (!bus.out_valid && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput(name, 64'(n), 64'(3));
   endtask

   task automatic waitDrain(input string name);
      for (int k = 0; k < 100 && sbQ.size() > 0; k++) begin
         @(posedge clk);
         #1;
      end
      checkOutput(name, 64'(sbQ.size()), 64'(0));
   endtask

   // Monitor: pops on every transfer and holds stalled outputs for comparison.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         holding = 0;
      end else if (bus.out_valid) begin
         if (holding)
            checkOutput("stall_stable", 64'({bus.out_flags, bus.out_data}),
                        64'({holdFlags, holdData}));
         if (bus.out_ready) begin
            holding = 0;
            received++;
            if (sbQ.size() == 0) begin
               checks++;
               $display("[TB] FAIL unexpected_output: actual 0x%0h, required no output", bus.out_data);
            end else begin
               e = sbQ.pop_front();
               checkOutput($sformatf("vec%0d", e.id), 64'({bus.out_flags, bus.out_data}),
                           64'({e.flags, e.data}));
            end
         end else begin
            holding   = 1;
            holdData  = bus.out_data;
            holdFlags = bus.out_flags;
         end
      end else begin
         holding = 0;
      end
   end

   initial begin
      bit seen;
      int rxBefore;

      addVec(0, 10'(EXP_BIAS), 48'h4000_0000_0000, 0, 0, 32'h3F800000, 3'b000);
      addVec(1, 10'(EXP_BIAS), 48'h8000_0000_0000, 0, 0, 32'hC0000000, 3'b000);
      addVec(0, 10'(EXP_BIAS), 48'h0000_0010_0000, 0, 0, 32'h32800000, 3'b000);
      addVec(0, 10'(EXP_BIAS), 48'h4000_0040_0000, 0, 0, 32'h3F800000, 3'b001);
      addVec(0, 10'(EXP_BIAS), 48'h4000_00C0_0000, 0, 0, 32'h3F800002, 3'b001);
      addVec(0, 10'd254,       48'hFFFF_FFFF_FFFF, 0, 0, 32'h7F800000, 3'b101);
      addVec(0, 10'd0,         48'h4000_0000_0000, 0, 0, 32'h00000000, 3'b011);
      addVec(0, 10'(EXP_BIAS), 48'h4000_0000_0000, 1, 1, 32'h7FC00000, 3'b000);
      addVec(1, 10'd5,         48'h0000_0000_007B, 0, 1, 32'hFF800000, 3'b000);
      addVec(1, 10'(EXP_BIAS), 48'h0000_0000_0000, 0, 0, 32'h80000000, 3'b000);
      addVec(0, 10'(EXP_BIAS), 48'h7FFF_FFFF_FFFF, 0, 0, 32'h40000000, 3'b001);
      addVec(0, 10'd254,       48'h7FFF_FFFF_FFFF, 0, 0, 32'h7F800000, 3'b101);
      addVec(0, 10'd1,         48'h4000_0000_0000, 0, 0, 32'h00800000, 3'b000);
      addVec(1, 10'd254,       48'h4000_0000_0000, 0, 0, 32'hFF000000, 3'b000);
      addVec(0, 10'h3FB,       48'h8000_0000_0000, 0, 0, 32'h00000000, 3'b011);
      addVec(0, 10'(EXP_BIAS), 48'h4000_0040_0001, 0, 0, 32'h3F800001, 3'b001);

      bus.in_valid = 1'b0; bus.in_sign = 1'b0; bus.in_exp = '0; bus.in_mant = '0;
      bus.in_nan = 1'b0; bus.in_inf = 1'b0; bus.out_ready = 1'b1;

      #12;
      checkOutput("reset_out_valid", 64'(bus.out_valid), 64'(0));
      checkOutput("reset_out_data",  64'(bus.out_data),  64'(0));
      checkOutput("reset_out_flags", 64'(bus.out_flags), 64'(0));
      #5 rst_n = 1'b1;
      @(posedge clk); #1;
      checkOutput("reset_in_ready", 64'(bus.in_ready), 64'(1));

      $display("[TB] single beat latency");
      applyStimulus(vecs[0], 0);
      measureLatency("latency_first");
      waitDrain("drain_first");

      $display("[TB] directed vectors back to back");
      foreach (vecs[i]) applyStimulus(vecs[i], i);
      waitDrain("drain_directed");

      $display("[TB] backpressure");
      rxBefore = received;
      fork
         begin
            for (int i = 0; i < 6; i++) applyStimulus(vecs[i], 100 + i);
         end
         begin
            @(posedge clk); #1;
            bus.out_ready = 1'b0;
            repeat (6) @(posedge clk);
            @(negedge clk);
            checkOutput("bp_in_ready_low", 64'(bus.in_ready), 64'(0));
            @(posedge clk); #1;
            bus.out_ready = 1'b1;
         end
      join
      waitDrain("drain_bp");
      checkOutput("bp_count", 64'(received - rxBefore), 64'(6));

      $display("[TB] reset mid-flight");
      bus.out_ready = 1'b0;
      applyStimulus(vecs[1], 300);
      applyStimulus(vecs[4], 301);
      @(posedge clk); #3;
      rst_n = 1'b0;
      expectedOut -= sbQ.size();
      sbQ.delete();
      #1;
      checkOutput("rst_out_valid", 64'(bus.out_valid), 64'(0));
      checkOutput("rst_out_data",  64'(bus.out_data),  64'(0));
      checkOutput("rst_in_ready",  64'(bus.in_ready),  64'(1));
      bus.out_ready = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus.out_valid) seen = 1;
      end
      checkOutput("rst_no_stale", 64'(seen), 64'(0));
      @(posedge clk); #1;
      applyStimulus(vecs[10], 400);
      measureLatency("latency_after_reset");
      waitDrain("drain_after_reset");

      repeat (3) @(posedge clk);
      checkOutput("received_total", 64'(received), 64'(expectedOut));
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
